sap_ctrl_seq: RTL
=================

Name: sap_ctrl_seq

Overview:
- Controller-sequencer for the SAP datapath; the control end of the shared 8-bit bus.
- Generates the five bus-driver enables consumed by the bus mux (ir_en, adder_en, a_en, mem_en, pc_en).
- Also generates the load strobes for the bus receivers, plus pc_inc, sub and halt.
- Sequences fixed T1..T6 machine cycles, decoding the IR opcode nibble.

Parameters:
- OPCODE_W, 4: width of the opcode field from the IR upper nibble.
- HALT_ON_UNKNOWN, 0: 1 = an undefined opcode halts at T4; 0 = it executes as NOP.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ir_opcode  in  OPCODE_W  current IR[7:4]
- ir_en, adder_en, a_en, mem_en, pc_en  out  1 each  bus-driver enables
- mar_ld, ir_ld, a_ld, b_ld, out_ld  out  1 each  bus-receiver loads (capture on next clk edge)
- pc_inc  out  1  PC increment
- sub  out  1  ALU subtract select
- halt  out  1  sticky halt indicator
- t_state  out  6  one-hot current T-state (bit0 = T1); all zero in IDLE and HALT

Behaviour:
- Single clock and single reset domain.
- Reset is asynchronous, active-low:
  - state <= IDLE.
  - All outputs are 0 during reset, including t_state.
- State register states: IDLE, T1..T6, HALT.
- Outputs are combinational decode of the registered state plus ir_opcode. No output latency beyond the state register.
- IDLE -> T1 on the first clk after rst_n deasserts. IDLE drives all outputs 0.
- Ring order: T1 -> T2 -> ... -> T6 -> T1.
- Opcodes:
  - LDA = 0000
  - ADD = 0001
  - SUB = 0010
  - OUT = 1110
  - HLT = 1111
- Fetch, opcode-independent:
  - T1: pc_en, mar_ld.
  - T2: pc_inc.
  - T3: mem_en, ir_ld.
- T4:
  - LDA / ADD / SUB: ir_en, mar_ld (the IR low nibble addresses memory).
  - OUT: a_en, out_ld.
  - HLT: halt=1; next state HALT.
- T5:
  - LDA: mem_en, a_ld.
  - ADD / SUB: mem_en, b_ld.
  - Others: nothing asserted.
- T6:
  - ADD: adder_en, a_ld.
  - SUB: adder_en, a_ld, sub.
  - Others: nothing asserted.
- ir_opcode is sampled only in T4..T6. The IR changes only at the T3->T4 edge, so the opcode is stable for T4..T6.
- Bus-enable invariant: at most one of the five *_en outputs is high in any cycle. The bench asserts this every cycle.
- Undefined opcode:
  - HALT_ON_UNKNOWN=0: T4..T6 assert nothing.
  - HALT_ON_UNKNOWN=1: behaves as HLT.
- HALT state:
  - Absorbing; halt=1, every other output 0.
  - Left only via rst_n.
- Reset mid-instruction: asynchronous return to IDLE; outputs go to 0 immediately, without waiting for a clock.
- No external start/stall inputs; the sequencer free-runs after reset.

Optional Feature:
- Macro: SAP_CTRL_SKIP_NOP_EN (variable machine cycle).
- Defined:
  - After a T-state, if every remaining T-state of the current opcode asserts nothing, the next state is T1 instead of the next T-state.
  - Resulting cycle lengths: LDA 5 cycles; OUT 4; undefined opcode with HALT_ON_UNKNOWN=0 is 3 (T3 -> T1); ADD/SUB 6.
- Undefined: every instruction takes the full T1..T6.

Decomposition:
- Package sap_pkg holds:
  - Opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT).
  - The state enum (S_IDLE, S_T1..S_T6, S_HALT).
  - A control-word struct bundling all enable/load bits.
- One natural sub-module: sap_ring_counter.
  - Holds the state register and next-state logic, including the skip logic.
  - The top decodes the control word from state and opcode.

Test Plan:
- Reset, then LDA: hold rst_n=0, then release with opcode=0000.
  - During reset all outputs are 0.
  - Cycle 1 after release: IDLE. Cycle 2: T1 with pc_en=mar_ld=1, t_state=000001.
  - T4: ir_en, mar_ld. T5: mem_en, a_ld.
- SUB: opcode=0010 → T6 shows adder_en=a_ld=sub=1; other outputs 0.
- OUT then HLT:
  - opcode=1110 → T4 shows a_en=out_ld=1.
  - Next instruction opcode=1111 → halt=1 at T4, then HALT for ≥20 cycles: halt=1, t_state=0, all enables 0.
- Mid-instruction reset: assert rst_n=0 during T5 of ADD → outputs 0 within the same cycle (asynchronous); after release the sequence restarts IDLE→T1.
- SKIP_NOP: with SAP_CTRL_SKIP_NOP_EN, run LDA, OUT, ADD back to back.
  - T1 occurs at cycles 0, 5, 9; the ADD lasts 6 cycles.
  - Without the macro, T1 occurs every 6 cycles.
- Invariant sweep: random opcodes (including 0011..1101) for 1000 cycles with both HALT_ON_UNKNOWN values.
  - The one-hot-or-zero bus-enable check never fails.
  - Undefined opcodes give zero T4..T6 activity, or halt, matching HALT_ON_UNKNOWN.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP controller-sequencer: opcode values, the
// sequencer state encoding, the opcode classes used by decode and sequencing,
// and the control word that bundles every enable/load strobe.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  // Undefined opcodes fold into OC_HLT or OC_UNK depending on HALT_ON_UNKNOWN,
  // so neither the sequencer nor the decoder needs to know that parameter.
  typedef enum logic [2:0] {
    OC_LDA,
    OC_ADD,
    OC_SUB,
    OC_OUT,
    OC_HLT,
    OC_UNK
  } op_class_t;

  typedef struct packed {
    logic ir_en;
    logic adder_en;
    logic a_en;
    logic mem_en;
    logic pc_en;
    logic mar_ld;
    logic ir_ld;
    logic a_ld;
    logic b_ld;
    logic out_ld;
    logic pc_inc;
    logic sub;
    logic halt;
  } ctrl_word_t;

endpackage

// File: rtl/sap_ring_counter.sv
// T-state ring counter for the SAP sequencer: holds the state register and
// chooses the next T-state from the current opcode class.
// Optional macro SAP_CTRL_SKIP_NOP_EN: when defined, the ring returns to T1
// as soon as every remaining T-state of the instruction would be idle.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  op_class_t op_class,
  output state_t    state
);

  state_t state_nxt;

  // State register; reset parks the ring in IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection: fixed fetch, opcode-dependent exit from T4..T6.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
`ifdef SAP_CTRL_SKIP_NOP_EN
      // The short NOP cycle needs the upcoming opcode to be presented at T3.
      S_T3:   state_nxt = (op_class == OC_UNK) ? S_T1 : S_T4;
      S_T4: begin
        if (op_class == OC_HLT) begin
          state_nxt = S_HALT;
        end else if (op_class == OC_OUT || op_class == OC_UNK) begin
          state_nxt = S_T1;
        end else begin
          state_nxt = S_T5;
        end
      end
      S_T5:   state_nxt = (op_class == OC_ADD || op_class == OC_SUB) ? S_T6 : S_T1;
`else
      S_T3:   state_nxt = S_T4;
      S_T4:   state_nxt = (op_class == OC_HLT) ? S_HALT : S_T5;
      S_T5:   state_nxt = S_T6;
`endif
      S_T6:   state_nxt = S_T1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP controller-sequencer: runs the T1..T6 machine cycle and decodes the
// bus-driver enables and bus-receiver load strobes from the T-state and the
// IR opcode nibble. Outputs are purely combinational from the registered state.
// Optional macro SAP_CTRL_SKIP_NOP_EN shortens instructions whose trailing
// T-states are idle (handled inside sap_ring_counter).
module sap_ctrl_seq
  import sap_pkg::*;
#(
  parameter int OPCODE_W        = 4,
  parameter bit HALT_ON_UNKNOWN = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] ir_opcode,
  output logic                ir_en,
  output logic                adder_en,
  output logic                a_en,
  output logic                mem_en,
  output logic                pc_en,
  output logic                mar_ld,
  output logic                ir_ld,
  output logic                a_ld,
  output logic                b_ld,
  output logic                out_ld,
  output logic                pc_inc,
  output logic                sub,
  output logic                halt,
  output logic [5:0]          t_state
);

  state_t     state;
  op_class_t  op_class;
  ctrl_word_t cw;

  // Opcode classification; anything outside the defined set is unknown.
  always_comb begin
    op_class = HALT_ON_UNKNOWN ? OC_HLT : OC_UNK;
    if (ir_opcode == OPCODE_W'(OP_LDA)) begin
      op_class = OC_LDA;
    end else if (ir_opcode == OPCODE_W'(OP_ADD)) begin
      op_class = OC_ADD;
    end else if (ir_opcode == OPCODE_W'(OP_SUB)) begin
      op_class = OC_SUB;
    end else if (ir_opcode == OPCODE_W'(OP_OUT)) begin
      op_class = OC_OUT;
    end else if (ir_opcode == OPCODE_W'(OP_HLT)) begin
      op_class = OC_HLT;
    end
  end

  sap_ring_counter u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_class (op_class),
    .state    (state)
  );

  // Control-word decode; at most one bus driver is enabled per T-state.
  always_comb begin
    cw = '0;
    case (state)
      S_T1: begin
        cw.pc_en  = 1'b1;
        cw.mar_ld = 1'b1;
      end
      S_T2: cw.pc_inc = 1'b1;
      S_T3: begin
        cw.mem_en = 1'b1;
        cw.ir_ld  = 1'b1;
      end
      S_T4: begin
        case (op_class)
          OC_LDA, OC_ADD, OC_SUB: begin
            // IR low nibble is the operand address.
            cw.ir_en  = 1'b1;
            cw.mar_ld = 1'b1;
          end
          OC_OUT: begin
            cw.a_en   = 1'b1;
            cw.out_ld = 1'b1;
          end
          OC_HLT: cw.halt = 1'b1;
          default: cw = '0;
        endcase
      end
      S_T5: begin
        case (op_class)
          OC_LDA: begin
            cw.mem_en = 1'b1;
            cw.a_ld   = 1'b1;
          end
          OC_ADD, OC_SUB: begin
            cw.mem_en = 1'b1;
            cw.b_ld   = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      S_T6: begin
        case (op_class)
          OC_ADD: begin
            cw.adder_en = 1'b1;
            cw.a_ld     = 1'b1;
          end
          OC_SUB: begin
            cw.adder_en = 1'b1;
            cw.a_ld     = 1'b1;
            cw.sub      = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      S_HALT: cw.halt = 1'b1;
      default: cw = '0;
    endcase
  end

  // One-hot T-state indicator; zero in IDLE and HALT.
  always_comb begin
    t_state = '0;
    case (state)
      S_T1:    t_state = 6'b000001;
      S_T2:    t_state = 6'b000010;
      S_T3:    t_state = 6'b000100;
      S_T4:    t_state = 6'b001000;
      S_T5:    t_state = 6'b010000;
      S_T6:    t_state = 6'b100000;
      default: t_state = '0;
    endcase
  end

  assign ir_en    = cw.ir_en;
  assign adder_en = cw.adder_en;
  assign a_en     = cw.a_en;
  assign mem_en   = cw.mem_en;
  assign pc_en    = cw.pc_en;
  assign mar_ld   = cw.mar_ld;
  assign ir_ld    = cw.ir_ld;
  assign a_ld     = cw.a_ld;
  assign b_ld     = cw.b_ld;
  assign out_ld   = cw.out_ld;
  assign pc_inc   = cw.pc_inc;
  assign sub      = cw.sub;
  assign halt     = cw.halt;

endmodule
